// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage.
// MEM->WB bus layout, CP0 addresses, ExcCodes, Status/Cause bits.
package wb_stage_pkg;

    // MSB first; total width 161 bits.
    typedef struct packed {
        logic        rsvd;
        logic        inst_jbr;
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0_addr;
        logic        syscall;
        logic        brk;
        logic        ov_ex;
        logic        adel_ex;
        logic        ades_ex;
        logic        ri_ex;
        logic        eret;
        logic [31:0] exe_result;
        logic [31:0] pc;
        logic [3:0]  wbytes;
    } mem_wb_t;

    localparam int BUS_W = 161;

    // CP0 addresses encoded as {reg, sel}.
    localparam logic [7:0] CP0_BADVADDR = 8'd64;
    localparam logic [7:0] CP0_COUNT    = 8'd72;
    localparam logic [7:0] CP0_COMPARE  = 8'd88;
    localparam logic [7:0] CP0_STATUS   = 8'd96;
    localparam logic [7:0] CP0_CAUSE    = 8'd104;
    localparam logic [7:0] CP0_EPC      = 8'd112;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_TI  = 30;
    localparam int CA_BD  = 31;

    // Victim PC for EPC: a delay-slot fault points back at the branch.
    function automatic logic [31:0] victim_pc(
        input logic        bd,
        input logic [31:0] pc
    );
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/wb_cp0.sv
// CP0 registers, Count/Compare timer, interrupt and exception commit.
// Ports: instruction flags in; take/eret_take, read data, CP0 views out.
module wb_cp0
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        mtc0,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] exe_result,
    input  logic [31:0] pc,
    input  logic        inst_jbr,
    input  logic        adel,
    input  logic        ades,
    input  logic        ri,
    input  logic        ov,
    input  logic        sys,
    input  logic        brk,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic        take,
    output logic        eret_take,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic [31:0] badvaddr
);

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        count_half;
    logic        prev_jbr;

    logic        int_pend;
    logic        any_exc;
    logic        wr;
    logic        wr_count;
    logic        wr_compare;
    logic [4:0]  code;
    logic [31:0] count_next;

    assign int_pend = status_q[ST_IE] & ~status_q[ST_EXL]
                    & |(status_q[15:8] & cause_q[15:8]);

    assign any_exc = adel | ades | ri | ov | sys | brk;

    assign take      = valid & (int_pend | any_exc);
    assign eret_take = valid & eret & ~take;

    // An excepting instruction must not commit its mtc0.
    assign wr         = valid & mtc0 & ~take;
    assign wr_count   = wr & (cp0_addr == CP0_COUNT);
    assign wr_compare = wr & (cp0_addr == CP0_COMPARE);
    assign count_next = count_q + 32'd1;

    always_comb begin
        code = EXC_INT;
        priority case (1'b1)
            int_pend: code = EXC_INT;
            adel:     code = EXC_ADEL;
            ri:       code = EXC_RI;
            ov:       code = EXC_OV;
            sys:      code = EXC_SYS;
            brk:      code = EXC_BP;
            ades:     code = EXC_ADES;
            default:  code = EXC_INT;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        unique case (cp0_addr)
            CP0_STATUS:   rdata = status_q;
            CP0_CAUSE:    rdata = cause_q;
            CP0_EPC:      rdata = epc_q;
            CP0_BADVADDR: rdata = badvaddr_q;
            CP0_COUNT:    rdata = count_q;
            CP0_COMPARE:  rdata = compare_q;
            default:      rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            count_half <= 1'b0;
            prev_jbr   <= 1'b0;
        end else begin
            count_half <= ~count_half;

            if (wr_count) begin
                count_q <= wdata;
            end else if (count_half) begin
                count_q <= count_next;
            end

            // Compare write clears TI and beats a same-cycle match.
            if (wr_compare) begin
                compare_q      <= wdata;
                cause_q[CA_TI] <= 1'b0;
            end else if (count_half && !wr_count
                         && count_next == compare_q) begin
                cause_q[CA_TI] <= 1'b1;
            end

            // IP7 carries the timer alongside hw line 5.
            cause_q[15:10] <= {hw_int[5] | cause_q[CA_TI],
                               hw_int[4:0]};

            if (wr && cp0_addr == CP0_CAUSE) begin
                cause_q[9:8] <= wdata[9:8];
            end

            if (wr && cp0_addr == CP0_STATUS) begin
                status_q[15:8]   <= wdata[15:8];
                status_q[ST_EXL] <= wdata[ST_EXL];
                status_q[ST_IE]  <= wdata[ST_IE];
            end

            if (wr && cp0_addr == CP0_EPC) begin
                epc_q <= wdata;
            end

            if (take) begin
                status_q[ST_EXL] <= 1'b1;
                cause_q[6:2]     <= code;
                cause_q[CA_BD]   <= prev_jbr;
                // Nested faults keep the original return address.
                if (!status_q[ST_EXL]) begin
                    epc_q <= victim_pc(prev_jbr, pc);
                end
                if (code == EXC_ADEL || code == EXC_ADES) begin
                    badvaddr_q <= exe_result;
                end
            end else if (eret_take) begin
                status_q[ST_EXL] <= 1'b0;
            end

            if (take || eret_take) begin
                prev_jbr <= 1'b0;
            end else if (valid) begin
                prev_jbr <= inst_jbr;
            end
        end
    end

    assign status   = status_q;
    assign cause    = cause_q;
    assign epc      = epc_q;
    assign badvaddr = badvaddr_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: regfile/HI/LO commit, CP0 and fetch redirect.
// Ports: MEM_WB bus in; regfile, HI/LO, CP0 views, cancel/redirect out.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             WB_valid,
    input  logic [BUS_W-1:0] MEM_WB_bus_r,
    output logic             WB_over,
    output logic [3:0]       rf_wen,
    output logic [4:0]       rf_wdest,
    output logic [31:0]      rf_wdata,
    output logic [4:0]       WB_wdest,
    output logic [31:0]      HI_data,
    output logic [31:0]      LO_data,
    output logic [31:0]      WB_hi_data,
    output logic [31:0]      WB_lo_data,
    output logic             WB_hi_write,
    output logic             WB_lo_write,
    output logic [31:0]      cp0r_status,
    output logic [31:0]      cp0r_cause,
    output logic [31:0]      cp0r_epc,
    output logic [31:0]      cp0r_badvaddr,
    input  logic [5:0]       hw_int,
    output logic             cancel,
    output logic             exc_pc_valid,
    output logic [31:0]      exc_pc
);

    mem_wb_t     bus;
    logic        take;
    logic        eret_take;
    logic        redirect;
    logic [31:0] cp0_rdata;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] wdata_sel;
    logic        unused_rsvd;

    assign bus         = MEM_WB_bus_r;
    assign unused_rsvd = bus.rsvd;

    wb_cp0 #(
        .STATUS_RESET (STATUS_RESET)
    ) u_cp0 (
        .clk        (clk),
        .resetn     (resetn),
        .valid      (WB_valid),
        .mtc0       (bus.mtc0),
        .cp0_addr   (bus.cp0_addr),
        .wdata      (bus.mem_result),
        .exe_result (bus.exe_result),
        .pc         (bus.pc),
        .inst_jbr   (bus.inst_jbr),
        .adel       (bus.adel_ex),
        .ades       (bus.ades_ex),
        .ri         (bus.ri_ex),
        .ov         (bus.ov_ex),
        .sys        (bus.syscall),
        .brk        (bus.brk),
        .eret       (bus.eret),
        .hw_int     (hw_int),
        .take       (take),
        .eret_take  (eret_take),
        .rdata      (cp0_rdata),
        .status     (cp0r_status),
        .cause      (cp0r_cause),
        .epc        (cp0r_epc),
        .badvaddr   (cp0r_badvaddr)
    );

    always_comb begin
        wdata_sel = bus.mem_result;
        if (bus.mfc0) begin
            wdata_sel = cp0_rdata;
        end else if (bus.mfhi) begin
            wdata_sel = hi_q;
        end else if (bus.mflo) begin
            wdata_sel = lo_q;
        end
    end

    assign WB_over  = WB_valid;
    assign rf_wen   = {4{bus.wen & WB_valid & ~take}} & bus.wbytes;
    assign rf_wdest = WB_valid ? bus.wdest : 5'd0;
    assign rf_wdata = WB_valid ? wdata_sel : 32'd0;
    assign WB_wdest = (WB_valid & bus.wen) ? bus.wdest : 5'd0;

    assign WB_hi_data  = WB_valid ? bus.mem_result : 32'd0;
    assign WB_lo_data  = WB_valid ? bus.lo_result : 32'd0;
    assign WB_hi_write = WB_valid & bus.hi_write & ~take;
    assign WB_lo_write = WB_valid & bus.lo_write & ~take;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (WB_hi_write) begin
                hi_q <= bus.mem_result;
            end
            if (WB_lo_write) begin
                lo_q <= bus.lo_result;
            end
        end
    end

    assign HI_data = hi_q;
    assign LO_data = lo_q;

    // Reset in the same cycle suppresses any redirect.
    assign redirect     = resetn & (take | eret_take);
    assign cancel       = redirect;
    assign exc_pc_valid = redirect;

    always_comb begin
        exc_pc = 32'd0;
        if (redirect) begin
            exc_pc = take ? EXC_VECTOR : cp0r_epc;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table plus CP0 sequences.
// Checks regfile/HI/LO commit, exceptions, ERET, timer and reset.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic             clk;
    logic             resetn;
    logic             WB_valid;
    logic [BUS_W-1:0] MEM_WB_bus_r;
    logic             WB_over;
    logic [3:0]       rf_wen;
    logic [4:0]       rf_wdest;
    logic [31:0]      rf_wdata;
    logic [4:0]       WB_wdest;
    logic [31:0]      HI_data;
    logic [31:0]      LO_data;
    logic [31:0]      WB_hi_data;
    logic [31:0]      WB_lo_data;
    logic             WB_hi_write;
    logic             WB_lo_write;
    logic [31:0]      cp0r_status;
    logic [31:0]      cp0r_cause;
    logic [31:0]      cp0r_epc;
    logic [31:0]      cp0r_badvaddr;
    logic [5:0]       hw_int;
    logic             cancel;
    logic             exc_pc_valid;
    logic [31:0]      exc_pc;

    int n_chk;
    int n_fail;

    wb_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .WB_valid      (WB_valid),
        .MEM_WB_bus_r  (MEM_WB_bus_r),
        .WB_over       (WB_over),
        .rf_wen        (rf_wen),
        .rf_wdest      (rf_wdest),
        .rf_wdata      (rf_wdata),
        .WB_wdest      (WB_wdest),
        .HI_data       (HI_data),
        .LO_data       (LO_data),
        .WB_hi_data    (WB_hi_data),
        .WB_lo_data    (WB_lo_data),
        .WB_hi_write   (WB_hi_write),
        .WB_lo_write   (WB_lo_write),
        .cp0r_status   (cp0r_status),
        .cp0r_cause    (cp0r_cause),
        .cp0r_epc      (cp0r_epc),
        .cp0r_badvaddr (cp0r_badvaddr),
        .hw_int        (hw_int),
        .cancel        (cancel),
        .exc_pc_valid  (exc_pc_valid),
        .exc_pc        (exc_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        mem_wb_t     bus;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata;
        logic [4:0]  e_wdest;
        logic        e_redir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input mem_wb_t b);
        WB_valid     = v;
        MEM_WB_bus_r = b;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        WB_valid     = 1'b0;
        MEM_WB_bus_r = '0;
    endtask

    task automatic chk_redir(input string name,
                             input logic e,
                             input logic [31:0] epc_exp);
        chk({name, " cancel"}, {31'd0, cancel}, {31'd0, e});
        chk({name, " exc_pc_valid"}, {31'd0, exc_pc_valid},
            {31'd0, e});
        chk({name, " exc_pc"}, exc_pc, epc_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem_wb_t b;
        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        WB_valid = 1'b0;
        MEM_WB_bus_r = '0;
        hw_int = 6'd0;

        b = '0; b.wen = 1; b.wdest = 5'd5;
        b.mem_result = 32'h1234; b.wbytes = 4'hF;
        tbl[0] = '{1'b1, b, 4'hF, 32'h1234, 5'd5, 1'b0, 32'h0};
        b = '0; b.hi_write = 1; b.mem_result = 32'hAA;
        tbl[1] = '{1'b1, b, 4'h0, 32'hAA, 5'd0, 1'b0, 32'h0};
        b = '0; b.mfhi = 1; b.wen = 1; b.wdest = 5'd3;
        b.wbytes = 4'hF;
        tbl[2] = '{1'b1, b, 4'hF, 32'hAA, 5'd3, 1'b0, 32'h0};
        b = '0; b.wen = 1; b.wdest = 5'd8;
        b.wbytes = 4'hF; b.mem_result = 32'h77;
        tbl[3] = '{1'b0, b, 4'h0, 32'h0, 5'd0, 1'b0, 32'h0};
        b = '0; b.wen = 1; b.wdest = 5'd7;
        b.wbytes = 4'b0011; b.mem_result = 32'hDEAD_BEEF;
        tbl[4] = '{1'b1, b, 4'h3, 32'hDEAD_BEEF, 5'd7, 1'b0, 32'h0};
        b = '0; b.lo_write = 1; b.lo_result = 32'h55;
        tbl[5] = '{1'b1, b, 4'h0, 32'h0, 5'd0, 1'b0, 32'h0};
        b = '0; b.mflo = 1; b.wen = 1; b.wdest = 5'd9;
        b.wbytes = 4'hF;
        tbl[6] = '{1'b1, b, 4'hF, 32'h55, 5'd9, 1'b0, 32'h0};
        b = '0; b.mfc0 = 1; b.cp0_addr = CP0_STATUS;
        b.wen = 1; b.wdest = 5'd2; b.wbytes = 4'hF;
        tbl[7] = '{1'b1, b, 4'hF, 32'h0040_0000, 5'd2, 1'b0, 32'h0};
        b = '0; b.inst_jbr = 1; b.pc = 32'hBFC0_00FC;
        tbl[8] = '{1'b1, b, 4'h0, 32'h0, 5'd0, 1'b0, 32'h0};
        b = '0; b.ov_ex = 1; b.pc = 32'hBFC0_0100;
        b.wen = 1; b.wdest = 5'd4; b.wbytes = 4'hF;
        tbl[9] = '{1'b1, b, 4'h0, 32'h0, 5'd4, 1'b1, 32'hBFC0_0380};

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        chk("rst HI", HI_data, 32'h0);
        chk("rst LO", LO_data, 32'h0);
        chk("rst status", cp0r_status, 32'h0040_0000);
        chk("rst cause", cp0r_cause, 32'h0);
        chk("rst epc", cp0r_epc, 32'h0);
        chk("rst rf_wen", {28'd0, rf_wen}, 32'h0);
        chk("rst cancel", {31'd0, cancel}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].bus);
            chk($sformatf("v%0d rf_wen", i),
                {28'd0, rf_wen}, {28'd0, tbl[i].e_wen});
            chk($sformatf("v%0d rf_wdata", i),
                rf_wdata, tbl[i].e_wdata);
            chk($sformatf("v%0d WB_wdest", i),
                {27'd0, WB_wdest}, {27'd0, tbl[i].e_wdest});
            chk($sformatf("v%0d WB_over", i),
                {31'd0, WB_over}, {31'd0, tbl[i].valid});
            chk_redir($sformatf("v%0d", i),
                      tbl[i].e_redir, tbl[i].e_pc);
            nxt();
        end

        chk("ov HI", HI_data, 32'hAA);
        chk("ov LO", LO_data, 32'h55);
        chk("ov epc", cp0r_epc, 32'hBFC0_00FC);
        chk("ov cause", cp0r_cause, 32'h8000_0030);
        chk("ov status", cp0r_status, 32'h0040_0002);

        b = '0; b.eret = 1;
        drive(1'b1, b);
        chk_redir("eret1", 1'b1, 32'hBFC0_00FC);
        nxt();
        chk("eret1 status", cp0r_status, 32'h0040_0000);

        b = '0; b.adel_ex = 1; b.exe_result = 32'h8000_0003;
        b.pc = 32'hBFC0_0200;
        drive(1'b1, b);
        chk_redir("adel", 1'b1, 32'hBFC0_0380);
        nxt();
        chk("adel badvaddr", cp0r_badvaddr, 32'h8000_0003);
        chk("adel cause", cp0r_cause, 32'h0000_0010);
        chk("adel epc", cp0r_epc, 32'hBFC0_0200);

        b = '0; b.eret = 1;
        drive(1'b1, b);
        chk_redir("eret2", 1'b1, 32'hBFC0_0200);
        nxt();
        chk("eret2 status", cp0r_status, 32'h0040_0000);

        b = '0; b.mtc0 = 1; b.cp0_addr = CP0_EPC;
        b.mem_result = 32'h1111; b.syscall = 1; b.pc = 32'h100;
        drive(1'b1, b);
        chk_redir("sys", 1'b1, 32'hBFC0_0380);
        nxt();
        chk("sys epc", cp0r_epc, 32'h100);
        chk("sys code", {27'd0, cp0r_cause[6:2]}, 32'd8);

        b = '0; b.brk = 1; b.pc = 32'h200;
        drive(1'b1, b);
        nxt();
        chk("nested epc", cp0r_epc, 32'h100);
        chk("nested code", {27'd0, cp0r_cause[6:2]}, 32'd9);

        b = '0; b.eret = 1;
        drive(1'b1, b);
        chk_redir("eret3", 1'b1, 32'h100);
        nxt();

        b = '0; b.mtc0 = 1; b.cp0_addr = CP0_COMPARE;
        b.mem_result = 32'd3;
        drive(1'b1, b);
        nxt();
        b.cp0_addr = CP0_COUNT; b.mem_result = 32'd0;
        drive(1'b1, b);
        nxt();
        b.cp0_addr = CP0_STATUS; b.mem_result = 32'h0000_8001;
        drive(1'b1, b);
        nxt();
        chk("tmr status", cp0r_status, 32'h0040_8001);
        repeat (12) @(posedge clk);
        #1;
        chk("tmr TI", {31'd0, cp0r_cause[CA_TI]}, 32'd1);
        chk("tmr IP7", {31'd0, cp0r_cause[15]}, 32'd1);

        b = '0; b.pc = 32'hBFC0_0300; b.wen = 1;
        b.wdest = 5'd6; b.wbytes = 4'hF;
        drive(1'b1, b);
        chk_redir("int", 1'b1, 32'hBFC0_0380);
        chk("int rf_wen", {28'd0, rf_wen}, 32'h0);
        nxt();
        chk("int epc", cp0r_epc, 32'hBFC0_0300);
        chk("int cause", cp0r_cause, 32'h4000_8000);
        chk("int status", cp0r_status, 32'h0040_8003);

        b = '0; b.mtc0 = 1; b.cp0_addr = CP0_COMPARE;
        b.mem_result = 32'hFFFF_FFFF;
        drive(1'b1, b);
        chk("cmp cancel", {31'd0, cancel}, 32'd0);
        nxt();
        chk("cmp TI clr", {31'd0, cp0r_cause[CA_TI]}, 32'd0);

        b = '0; b.ov_ex = 1; b.pc = 32'h500;
        b.hi_write = 1; b.mem_result = 32'h99;
        resetn = 1'b0;
        drive(1'b1, b);
        chk_redir("rst-exc", 1'b0, 32'h0);
        nxt();
        resetn = 1'b1;
        chk("rst2 HI", HI_data, 32'h0);
        chk("rst2 LO", LO_data, 32'h0);
        chk("rst2 status", cp0r_status, 32'h0040_0000);
        chk("rst2 cause", cp0r_cause, 32'h0);
        chk("rst2 epc", cp0r_epc, 32'h0);
        chk("rst2 badvaddr", cp0r_badvaddr, 32'h0);
        chk("rst2 cancel", {31'd0, cancel}, 32'h0);

        b = '0; b.mtc0 = 1; b.cp0_addr = CP0_STATUS;
        b.mem_result = 32'h0000_0401;
        drive(1'b1, b);
        nxt();
        hw_int = 6'b000001;
        repeat (2) @(posedge clk);
        #1;
        chk("hw idle cancel", {31'd0, cancel}, 32'd0);
        chk("hw IP2", {31'd0, cp0r_cause[10]}, 32'd1);
        b = '0; b.pc = 32'h400;
        drive(1'b1, b);
        chk_redir("hw int", 1'b1, 32'hBFC0_0380);
        nxt();
        chk("hw epc", cp0r_epc, 32'h400);
        chk("hw cause", cp0r_cause, 32'h0000_0400);
        chk("hw status", cp0r_status, 32'h0040_0403);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
